// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt/exception controller.
package irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_VECTOR  = 3'd2,
    ST_HANDLER = 3'd3,
    ST_HALT    = 3'd4
  } irq_state_t;

  localparam logic [1:0] CODE_EXC = 2'd1;
  localparam logic [1:0] CODE_IRQ = 2'd2;

  localparam logic [2:0] SEL_STATUS = 3'd0;
  localparam logic [2:0] SEL_MASK   = 3'd1;
  localparam logic [2:0] SEL_PEND   = 3'd2;
  localparam logic [2:0] SEL_CAUSE  = 3'd3;
  localparam logic [2:0] SEL_EPC    = 3'd4;

  localparam logic [31:0] VECTOR_DEFAULT = 32'h0000_0080;

  // Only code [7:6] and source [2:0] exist in CAUSE; all other bits read 0.
  localparam logic [7:0] CAUSE_WMASK = 8'hC7;

  function automatic logic [7:0] make_cause(input logic [1:0] code, input logic [2:0] src);
    return {code, 3'b000, src};
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Pipeline take-point handshake plus CP0 MFC/MTC access bus.
// master = interrupt controller side, slave = core side.
interface irq_ctrl_if;

  logic        take_ack;
  logic [31:0] epc_src;
  logic        rfe;
  logic        irq_req;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  cp0_sel;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;

  modport master (
    input  take_ack, epc_src, rfe, cp0_sel, cp0_we, cp0_wdata,
    output irq_req, flush, redirect, redirect_pc, cp0_rdata
  );

  modport slave (
    output take_ack, epc_src, rfe, cp0_sel, cp0_we, cp0_wdata,
    input  irq_req, flush, redirect, redirect_pc, cp0_rdata
  );

endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt/exception sequencer for the 5-stage pipeline with CP0 register file.
// Build option: define IRQ_EDGE_EN for rising-edge pending capture (default is level).
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          N_IRQ       = 4,
  parameter logic [31:0] VECTOR_ADDR = VECTOR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             wrong_inst,
  irq_ctrl_if.master       bus,
  output logic             in_handler,
  output logic             halt
);

  irq_state_t state, state_next;

  logic             ie;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] pend;
  logic [7:0]       cause;
  logic [31:0]      epc;
  logic             ret_pulse;

  logic [N_IRQ-1:0] pend_set;
  logic [N_IRQ-1:0] pend_clr;
  logic             irq_valid;
  logic [2:0]       irq_idx;
  logic             eligible;

  logic             cause_load;
  logic [7:0]       cause_value;
  logic             epc_load;
  logic             ie_clear;
  logic             ie_set;
  logic             ret_next;

  logic             wr_status;
  logic             wr_mask;
  logic             wr_pend;
  logic             wr_cause;
  logic             wr_epc;

`ifdef IRQ_EDGE_EN
  logic [N_IRQ-1:0] irq_prev;

  always_ff @(posedge clk) begin
    if (!rst) irq_prev <= '0;
    else      irq_prev <= irq_in;
  end

  assign pend_set = irq_in & ~irq_prev;
`else
  assign pend_set = irq_in;
`endif

  irq_prio_enc #(.N(N_IRQ)) u_prio (
    .req   (pend & mask),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  assign eligible = irq_valid && ie;

  assign wr_status = bus.cp0_we && (bus.cp0_sel == SEL_STATUS);
  assign wr_mask   = bus.cp0_we && (bus.cp0_sel == SEL_MASK);
  assign wr_pend   = bus.cp0_we && (bus.cp0_sel == SEL_PEND);
  // CAUSE/EPC are only patched by a handler preparing a nested return.
  assign wr_cause  = bus.cp0_we && (bus.cp0_sel == SEL_CAUSE) && (state == ST_HANDLER);
  assign wr_epc    = bus.cp0_we && (bus.cp0_sel == SEL_EPC)   && (state == ST_HANDLER);
  assign pend_clr  = wr_pend ? bus.cp0_wdata[N_IRQ-1:0] : '0;

  always_comb begin
    state_next  = state;
    cause_load  = 1'b0;
    cause_value = cause;
    epc_load    = 1'b0;
    ie_clear    = 1'b0;
    ie_set      = 1'b0;
    ret_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wrong_inst) begin
          cause_load  = 1'b1;
          cause_value = make_cause(CODE_EXC, 3'd0);
          state_next  = ST_REQ;
        end else if (eligible) begin
          cause_load  = 1'b1;
          cause_value = make_cause(CODE_IRQ, irq_idx);
          state_next  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wrong_inst) begin
          cause_load  = 1'b1;
          cause_value = make_cause(CODE_EXC, 3'd0);
        end
        if (bus.take_ack) begin
          epc_load   = 1'b1;
          state_next = ST_VECTOR;
        end
      end
      ST_VECTOR: begin
        ie_clear   = 1'b1;
        state_next = ST_HANDLER;
      end
      ST_HANDLER: begin
        // A fault inside the handler is unrecoverable, so it beats a same-cycle RFE.
        if (wrong_inst) begin
          state_next = ST_HALT;
        end else if (bus.rfe) begin
          ie_set     = 1'b1;
          ret_next   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      ret_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      ret_pulse <= ret_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ie    <= 1'b0;
      mask  <= '0;
      pend  <= '0;
      cause <= '0;
      epc   <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
      if (wr_mask) mask <= bus.cp0_wdata[N_IRQ-1:0];
      if (ie_clear)       ie <= 1'b0;
      else if (ie_set)    ie <= 1'b1;
      else if (wr_status) ie <= bus.cp0_wdata[0];
      if (cause_load)    cause <= cause_value;
      else if (wr_cause) cause <= bus.cp0_wdata[7:0] & CAUSE_WMASK;
      if (epc_load)      epc <= bus.epc_src;
      else if (wr_epc)   epc <= bus.cp0_wdata;
    end
  end

  // The return redirect is a registered pulse so it lands the cycle after RFE commits.
  always_comb begin
    bus.irq_req     = (state == ST_REQ);
    bus.flush       = (state == ST_VECTOR);
    bus.redirect    = (state == ST_VECTOR) || ret_pulse;
    bus.redirect_pc = '0;
    if (state == ST_VECTOR) bus.redirect_pc = VECTOR_ADDR;
    else if (ret_pulse)     bus.redirect_pc = epc;
    in_handler      = (state == ST_HANDLER);
    halt            = (state == ST_HALT);
  end

  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_sel)
      SEL_STATUS: bus.cp0_rdata = {31'b0, ie};
      SEL_MASK:   bus.cp0_rdata = 32'(mask);
      SEL_PEND:   bus.cp0_rdata = 32'(pend);
      SEL_CAUSE:  bus.cp0_rdata = {24'b0, cause};
      SEL_EPC:    bus.cp0_rdata = epc;
      default:    bus.cp0_rdata = '0;
    endcase
  end

endmodule
